// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle: master drives select/strobe/address/data/wait count,
// completer answers with registered ready, read data and error response.
interface apb_slave_mem_if #(
    parameter int WAIT_W = 4
);
    logic [1:0]        sel;
    logic              enable;
    logic              write;
    logic [7:0]        addr;
    logic [7:0]        wdata;
    logic [WAIT_W-1:0] wait_cycles;
    logic              ready;
    logic [7:0]        rdata;
    logic              slverr;

    modport master (
        output sel, enable, write, addr, wdata, wait_cycles,
        input  ready, rdata, slverr
    );

    modport slave (
        input  sel, enable, write, addr, wdata, wait_cycles,
        output ready, rdata, slverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer serving single transfers against a DEPTH x 8-bit register file.
// Latency: setup edge to completion edge is wait_cycles+1 clocks; all outputs registered.
// Backpressure: ready held low for wait_cycles enabled cycles; enable low in WAIT stalls the count.
module apb_slave_mem #(
    parameter logic [1:0] SLAVE_ID = 2'd1,
    parameter int         DEPTH    = 16,
    parameter int         WAIT_W   = 4
) (
    input  logic          clk,
    input  logic          reset,
    apb_slave_mem_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              ready_q, ready_nxt;
    logic              slverr_q, slverr_nxt;
    logic [7:0]        rdata_q, rdata_nxt;
    logic              latch_en;
    logic              mem_we;

    logic [AW-1:0]     idx_l;
    logic              write_l;
    logic [7:0]        wdata_l;
    logic              err_l;

    logic [7:0]        mem [DEPTH];

    logic              sel_hit;
    logic              setup_err;
    logic [7:0]        setup_rd;
    logic [7:0]        latched_rd;

    assign sel_hit    = (bus.sel == SLAVE_ID);
    assign setup_err  = ({1'b0, bus.addr} >= DEPTH_W);
    // Out-of-range reads return zero; the index is never used unguarded.
    assign setup_rd   = setup_err ? 8'h00 : mem[bus.addr[AW-1:0]];
    assign latched_rd = err_l ? 8'h00 : mem[idx_l];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ready_nxt  = ready_q;
        slverr_nxt = slverr_q;
        rdata_nxt  = rdata_q;
        latch_en   = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_hit && !bus.enable) begin
                    latch_en = 1'b1;
                    if (bus.wait_cycles == '0) begin
                        state_nxt  = S_ACCESS;
                        ready_nxt  = 1'b1;
                        slverr_nxt = setup_err;
                        if (!bus.write) begin
                            rdata_nxt = setup_rd;
                        end
                    end else begin
                        cnt_nxt   = bus.wait_cycles;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!sel_hit) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (bus.enable) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == WAIT_W'(1)) begin
                        state_nxt  = S_ACCESS;
                        ready_nxt  = 1'b1;
                        slverr_nxt = err_l;
                        if (!write_l) begin
                            rdata_nxt = latched_rd;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (!sel_hit) begin
                    state_nxt  = S_IDLE;
                    ready_nxt  = 1'b0;
                    slverr_nxt = 1'b0;
                end else if (bus.enable) begin
                    mem_we     = write_l && !err_l;
                    state_nxt  = S_IDLE;
                    ready_nxt  = 1'b0;
                    slverr_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= 8'h00;
            idx_l    <= '0;
            write_l  <= 1'b0;
            wdata_l  <= 8'h00;
            err_l    <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            ready_q  <= ready_nxt;
            slverr_q <= slverr_nxt;
            rdata_q  <= rdata_nxt;
            if (latch_en) begin
                idx_l   <= bus.addr[AW-1:0];
                write_l <= bus.write;
                wdata_l <= bus.wdata;
                err_l   <= setup_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem[idx_l] <= wdata_l;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.rdata  = rdata_q;
    assign bus.slverr = slverr_q;
endmodule
